// File: rtl/sha256_digest_reader_pkg.sv
// Shared definitions for the SHA-256 digest read-out path: widths, the
// SHA-256 initial hash values and the read-out FSM encoding.
package sha256_digest_reader_pkg;

    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;

    // SHA-256 initial hash values (FIPS 180-4)
    localparam logic [WORD_W-1:0] H0_INIT = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1_INIT = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2_INIT = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3_INIT = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4_INIT = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5_INIT = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6_INIT = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7_INIT = 32'h5be0cd19;

    // Read-out FSM: IDLE waits for a snapshot, SEND streams it
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_t;

    // Number of output beats needed for one full digest
    function automatic int beats_for(input int out_w);
        return DIGEST_W / out_w;
    endfunction

endpackage

// File: rtl/sha256_digest_reader.sv
// Snapshots the eight SHA-256 hash words on load and streams the 256-bit
// digest out MSB first (H0 first) over a valid/ready interface. The hash
// bank is free to reload as soon as the snapshot is taken.
module sha256_digest_reader
    import sha256_digest_reader_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [255:0]        digest_in,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                load_err
);

    localparam int BEATS = beats_for(OUT_W);
    localparam int CNT_W = $clog2(BEATS);

    // Only byte and word beats are supported by the downstream paths
    generate
        if (OUT_W != 8 && OUT_W != 32) begin : g_bad_out_w
            $error("sha256_digest_reader: OUT_W must be 8 or 32");
        end
    endgenerate

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;
    logic [DIGEST_W-1:0]    r_shreg;
    logic [DIGEST_W-1:0]    w_shreg_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_load_err;
    logic                   w_load_err_nxt;
    logic                   w_hs;
    logic                   w_last;

    assign w_hs   = out_valid & out_ready;
    assign w_last = (r_cnt == CNT_W'(BEATS - 1));

    // State, snapshot, beat counter and error flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Next state and datapath: capture, shift per accepted beat, chain digests
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_cnt_nxt      = r_cnt;
        w_load_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_shreg_nxt = digest_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_hs && w_last) begin
                    // Final beat accepted: a coincident load starts the next
                    // digest without an idle cycle in between
                    w_cnt_nxt = '0;
                    if (load) begin
                        w_shreg_nxt = digest_in;
                    end else begin
                        w_shreg_nxt = r_shreg << OUT_W;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_shreg_nxt = r_shreg << OUT_W;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                    // Snapshot is still being streamed; refuse the new one
                    w_load_err_nxt = load;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; data comes straight off the shift register top
    always_comb begin
        busy      = (r_state == ST_SEND);
        out_valid = (r_state == ST_SEND);
        out_last  = (r_state == ST_SEND) && w_last;
        out_data  = r_shreg[DIGEST_W-1 -: OUT_W];
        load_err  = r_load_err;
    end

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Scoreboard bench: stimulus pushes expected beats into per-width queues,
// a negedge monitor pops and compares on every accepted beat.
module tb_sha256_digest_reader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         load32 = 1'b0, load8 = 1'b0;
    logic [255:0] din32 = '0, din8 = '0;
    logic         rdy32 = 1'b1, rdy8 = 1'b1;
    logic [31:0]  d32;
    logic [7:0]   d8;
    logic         v32, v8, l32, l8, b32, b8, e32, e8;

    int           errors = 0;
    int           checks = 0;

    logic [32:0]  q32[$];
    logic [8:0]   q8[$];
    logic         stall32_prev = 1'b0;
    logic [31:0]  held32 = '0;

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    always #5 clk = ~clk;

    sha256_digest_reader #(.OUT_W(32)) u32 (
        .clk(clk), .reset_n(reset_n), .load(load32), .digest_in(din32),
        .out_data(d32), .out_valid(v32), .out_ready(rdy32), .out_last(l32),
        .busy(b32), .load_err(e32));

    sha256_digest_reader #(.OUT_W(8)) u8 (
        .clk(clk), .reset_n(reset_n), .load(load8), .digest_in(din8),
        .out_data(d8), .out_valid(v8), .out_ready(rdy8), .out_last(l8),
        .busy(b8), .load_err(e8));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of the first n words of a digest on the 32-bit stream
    task automatic push32(input logic [255:0] d, input int n);
        for (int i = 0; i < n; i++)
            q32.push_back({(i == 7), d[255 - 32*i -: 32]});
    endtask

    task automatic push8(input logic [255:0] d);
        for (int i = 0; i < 32; i++)
            q8.push_back({(i == 31), d[255 - 8*i -: 8]});
    endtask

    task automatic wait_idle32(input string nm);
        for (int i = 0; i < 100 && b32; i++) step();
        check(nm, {63'd0, b32}, 64'd0);
    endtask

    // Monitor: compare every accepted beat against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (v32 && stall32_prev)
                check("stall32_hold", {32'd0, d32}, {32'd0, held32});
            if (v32 && rdy32) begin
                if (q32.size() == 0) begin
                    check("beat32_unexpected", {31'd0, l32, d32}, 64'd0);
                end else begin
                    check("beat32", {31'd0, l32, d32}, {31'd0, q32.pop_front()});
                end
            end
            if (v8 && rdy8) begin
                if (q8.size() == 0) begin
                    check("beat8_unexpected", {55'd0, l8, d8}, 64'd0);
                end else begin
                    check("beat8", {55'd0, l8, d8}, {55'd0, q8.pop_front()});
                end
            end
            stall32_prev <= v32 && !rdy32;
            held32       <= d32;
        end else begin
            stall32_prev <= 1'b0;
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_valid", {62'd0, v32, v8}, 64'd0);
        check("rst_busy",  {62'd0, b32, b8}, 64'd0);
        check("rst_data",  {24'd0, d32, d8}, 64'd0);
        check("rst_last_err", {60'd0, l32, l8, e32, e8}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // 1: "abc" digest, 8 word beats, ready held high
        push32(ABC, 8);
        din32 = ABC; load32 = 1'b1;
        step();
        load32 = 1'b0;
        check("t1_busy", {63'd0, b32}, 64'd1);
        check("t1_first", {32'd0, d32}, 64'hba7816bf);
        wait_idle32("t1_idle");

        // 2: same digest on the byte-wide instance
        push8(ABC);
        din8 = ABC; load8 = 1'b1;
        step();
        load8 = 1'b0;
        for (int i = 0; i < 100 && b8; i++) step();
        check("t2_idle", {63'd0, b8}, 64'd0);

        // 3: stall on beat 2
        push32(ABC, 8);
        load32 = 1'b1;
        step();
        load32 = 1'b0;
        step();
        rdy32 = 1'b0;
        step(); step();
        check("t3_held", {32'd0, d32}, 64'h8f01cfea);
        rdy32 = 1'b1;
        wait_idle32("t3_idle");

        // 4: load during beat 3 is rejected with a one-cycle error pulse
        push32(ABC, 8);
        load32 = 1'b1;
        step();
        load32 = 1'b0;
        step(); step();
        din32 = IV; load32 = 1'b1;
        step();
        load32 = 1'b0;
        check("t4_err", {63'd0, e32}, 64'd1);
        check("t4_next", {32'd0, d32}, 64'h5dae2223);
        step();
        check("t4_err_clr", {63'd0, e32}, 64'd0);
        wait_idle32("t4_idle");

        // 5: load coincident with last-beat handshake chains without a bubble
        push32(ABC, 8);
        din32 = ABC; load32 = 1'b1;
        step();
        load32 = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("t5_last", {63'd0, l32}, 64'd1);
        push32(IV, 8);
        din32 = IV; load32 = 1'b1;
        step();
        load32 = 1'b0;
        check("t5_chain", {30'd0, e32, v32, d32}, {30'd0, 2'b01, 32'h6a09e667});
        wait_idle32("t5_idle");

        // 6: asynchronous reset at beat 5 discards the rest of the digest
        push32(IV, 4);
        load32 = 1'b1;
        step();
        load32 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset_n = 1'b0;
        #1;
        check("t6_abort", {30'd0, v32, b32, d32}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_resume", {62'd0, v32, b32}, 64'd0);
        end

        check("q32_empty", 64'(q32.size()), 64'd0);
        check("q8_empty", 64'(q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
